// File: rtl/ahb_mux_pkg.sv
// Shared AHB-Lite encodings for the arbiter, master mux and slave mux,
// plus the fixed-burst beat-count helper.
package ahb_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Undefined-length bursts (SINGLE/INCR) report 0 beats.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Counts the remaining beats of a fixed-length burst so the arbiter holds
// the grant until the last beat is accepted.
module ahb_burst_tracker
    import ahb_mux_pkg::*;
#(
    parameter int MIDX_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hready,
    input  logic              owner_vld,
    input  logic [MIDX_W-1:0] owner_idx,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hburst,
    output logic              burst_active
);

    logic [4:0]        beat_cnt, beat_cnt_nxt;
    logic              active_nxt;
    logic [MIDX_W-1:0] burst_owner, burst_owner_nxt;
    logic [4:0]        eff_cnt;
    logic              eff_active;
    logic [4:0]        beats;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt     <= '0;
            burst_active <= 1'b0;
            burst_owner  <= '0;
        end else begin
            beat_cnt     <= beat_cnt_nxt;
            burst_active <= active_nxt;
            burst_owner  <= burst_owner_nxt;
        end
    end

    always_comb begin
        beats           = burst_beats(hburst);
        eff_cnt         = beat_cnt;
        eff_active      = burst_active;
        burst_owner_nxt = burst_owner;
        // A new owner appearing mid-burst abandons the old burst before its
        // own transfer is evaluated.
        if (burst_active && (!owner_vld || owner_idx != burst_owner)) begin
            eff_cnt    = '0;
            eff_active = 1'b0;
        end
        beat_cnt_nxt = eff_cnt;
        active_nxt   = eff_active;
        if (hready) begin
            case (htrans)
                HTRANS_NONSEQ: begin
                    if (beats != 5'd0) begin
                        beat_cnt_nxt    = beats - 5'd1;
                        active_nxt      = 1'b1;
                        burst_owner_nxt = owner_idx;
                    end else begin
                        beat_cnt_nxt = '0;
                        active_nxt   = 1'b0;
                    end
                end
                HTRANS_SEQ: begin
                    if (eff_cnt != 5'd0) begin
                        beat_cnt_nxt = eff_cnt - 5'd1;
                        active_nxt   = (eff_cnt != 5'd1);
                    end
                end
                HTRANS_IDLE: begin
                    beat_cnt_nxt = '0;
                    active_nxt   = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_master_mux.sv
// AHB-Lite master-side mux: registers address/data-phase ownership on HREADY
// and forwards the owner's signals. Optional lock support via AHB_MUX_LOCK_EN.
module ahb_master_mux
    import ahb_mux_pkg::*;
#(
    parameter  int                NUM_MASTERS  = 5,
    parameter  int                ADDR_W       = 32,
    parameter  int                DATA_W       = 32,
    parameter  logic [ADDR_W-1:0] DEFAULT_ADDR = '0,
    localparam int                MIDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        hgrant_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] haddr_i,
    input  logic [NUM_MASTERS*2-1:0]      htrans_i,
    input  logic [NUM_MASTERS-1:0]        hwrite_i,
    input  logic [NUM_MASTERS*3-1:0]      hsize_i,
    input  logic [NUM_MASTERS*3-1:0]      hburst_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] hwdata_i,
    input  logic                          hready,
`ifdef AHB_MUX_LOCK_EN
    input  logic [NUM_MASTERS-1:0]        hmastlock_i,
    output logic                          hmastlock,
`endif
    output logic [ADDR_W-1:0]             haddr,
    output logic [1:0]                    htrans,
    output logic                          hwrite,
    output logic [2:0]                    hsize,
    output logic [2:0]                    hburst,
    output logic [DATA_W-1:0]             hwdata,
    output logic [MIDX_W-1:0]             hmaster,
    output logic                          hmaster_vld,
    output logic                          burst_active
);

    logic              addr_vld, data_vld;
    logic [MIDX_W-1:0] addr_idx, data_idx;
    logic [MIDX_W-1:0] grant_idx;
    logic              grant_ok;
    logic              trk_active;

    assign grant_ok = $onehot(hgrant_i);

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_i[i]) grant_idx = MIDX_W'(i);
        end
    end

    // Both phases stretch together under wait states.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_vld <= 1'b0;
            addr_idx <= '0;
            data_vld <= 1'b0;
            data_idx <= '0;
        end else if (hready) begin
            addr_vld <= grant_ok;
            addr_idx <= grant_ok ? grant_idx : '0;
            data_vld <= addr_vld;
            data_idx <= addr_idx;
        end
    end

    always_comb begin
        haddr       = DEFAULT_ADDR;
        htrans      = HTRANS_IDLE;
        hwrite      = 1'b0;
        hsize       = '0;
        hburst      = '0;
        hmaster     = '0;
        hmaster_vld = addr_vld;
        if (addr_vld) begin
            haddr   = haddr_i[int'(addr_idx)*ADDR_W +: ADDR_W];
            htrans  = htrans_i[int'(addr_idx)*2 +: 2];
            hwrite  = hwrite_i[addr_idx];
            hsize   = hsize_i[int'(addr_idx)*3 +: 3];
            hburst  = hburst_i[int'(addr_idx)*3 +: 3];
            hmaster = addr_idx;
        end
    end

    always_comb begin
        hwdata = '0;
        if (data_vld) hwdata = hwdata_i[int'(data_idx)*DATA_W +: DATA_W];
    end

    ahb_burst_tracker #(
        .MIDX_W (MIDX_W)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .hready       (hready),
        .owner_vld    (addr_vld),
        .owner_idx    (addr_idx),
        .htrans       (htrans),
        .hburst       (hburst),
        .burst_active (trk_active)
    );

`ifdef AHB_MUX_LOCK_EN
    assign hmastlock    = addr_vld ? hmastlock_i[addr_idx] : 1'b0;
    assign burst_active = trk_active | hmastlock;
`else
    assign burst_active = trk_active;
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench for ahb_master_mux: an ownership/burst model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ahb_master_mux;

    localparam int          NM  = 5;
    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam logic [31:0] DEF = 32'hDEAD_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic [NM-1:0]    hgrant_i;
    logic [NM*AW-1:0] haddr_i;
    logic [NM*2-1:0]  htrans_i;
    logic [NM-1:0]    hwrite_i;
    logic [NM*3-1:0]  hsize_i;
    logic [NM*3-1:0]  hburst_i;
    logic [NM*DW-1:0] hwdata_i;
    logic             hready;
    logic [AW-1:0]    haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [2:0]       hburst;
    logic [DW-1:0]    hwdata;
    logic [2:0]       hmaster;
    logic             hmaster_vld;
    logic             burst_active;
    logic [NM-1:0]    hmastlock_i;
    logic             hmastlock;

    logic [31:0] m_addr  [NM];
    logic [1:0]  m_trans [NM];
    logic        m_write [NM];
    logic [2:0]  m_size  [NM];
    logic [2:0]  m_burst [NM];
    logic [31:0] m_wdata [NM];
    logic        m_lock  [NM];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            haddr_i[i*AW +: AW]  = m_addr[i];
            htrans_i[i*2 +: 2]   = m_trans[i];
            hwrite_i[i]          = m_write[i];
            hsize_i[i*3 +: 3]    = m_size[i];
            hburst_i[i*3 +: 3]   = m_burst[i];
            hwdata_i[i*DW +: DW] = m_wdata[i];
            hmastlock_i[i]       = m_lock[i];
        end
    end

    ahb_master_mux #(
        .NUM_MASTERS  (NM),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .DEFAULT_ADDR (DEF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hgrant_i     (hgrant_i),
        .haddr_i      (haddr_i),
        .htrans_i     (htrans_i),
        .hwrite_i     (hwrite_i),
        .hsize_i      (hsize_i),
        .hburst_i     (hburst_i),
        .hwdata_i     (hwdata_i),
        .hready       (hready),
`ifdef AHB_MUX_LOCK_EN
        .hmastlock_i  (hmastlock_i),
        .hmastlock    (hmastlock),
`endif
        .haddr        (haddr),
        .htrans       (htrans),
        .hwrite       (hwrite),
        .hsize        (hsize),
        .hburst       (hburst),
        .hwdata       (hwdata),
        .hmaster      (hmaster),
        .hmaster_vld  (hmaster_vld),
        .burst_active (burst_active)
    );

`ifndef AHB_MUX_LOCK_EN
    assign hmastlock = 1'b0;
`endif

    // Model: owners as plain indices (-1 = none) and a remaining-beat count.
    int own = -1, down = -1, bown = -1, rem = 0;
    bit bact = 0, model_ok = 0;

    function automatic int beats_of(input logic [2:0] hb);
        if (hb == 3'd2 || hb == 3'd3) return 4;
        if (hb == 3'd4 || hb == 3'd5) return 8;
        if (hb == 3'd6 || hb == 3'd7) return 16;
        return 0;
    endfunction

    always @(posedge clk) begin
        int tr, n;
        if (reset) begin
            own = -1; down = -1; bown = -1; rem = 0; bact = 0;
            model_ok = 1;
        end else begin
            if (bact && own != bown) begin rem = 0; bact = 0; end
            if (hready) begin
                tr = (own >= 0) ? int'(m_trans[own]) : 0;
                n  = (own >= 0) ? beats_of(m_burst[own]) : 0;
                if (tr == 2) begin
                    if (n > 0) begin rem = n - 1; bact = 1; bown = own; end
                    else begin rem = 0; bact = 0; end
                end else if (tr == 3) begin
                    if (rem > 0) begin rem = rem - 1; bact = (rem > 0); end
                end else if (tr == 0) begin
                    rem = 0; bact = 0;
                end
                down = own;
                own = -1;
                if ($countones(hgrant_i) == 1)
                    for (int i = 0; i < NM; i++) if (hgrant_i[i]) own = i;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic lk;
        if (model_ok) begin
            lk = (own >= 0) ? m_lock[own] : 1'b0;
`ifndef AHB_MUX_LOCK_EN
            lk = 1'b0;
`endif
            chk("m_haddr",  64'(haddr),  64'((own >= 0) ? m_addr[own] : DEF));
            chk("m_htrans", 64'(htrans), 64'((own >= 0) ? m_trans[own] : 2'd0));
            chk("m_hwrite", 64'(hwrite), 64'((own >= 0) ? m_write[own] : 1'b0));
            chk("m_hsize",  64'(hsize),  64'((own >= 0) ? m_size[own] : 3'd0));
            chk("m_hburst", 64'(hburst), 64'((own >= 0) ? m_burst[own] : 3'd0));
            chk("m_hwdata", 64'(hwdata), 64'((down >= 0) ? m_wdata[down] : 32'd0));
            chk("m_hmaster", 64'(hmaster), 64'((own >= 0) ? own : 0));
            chk("m_hmaster_vld", 64'(hmaster_vld), 64'(own >= 0));
            chk("m_burst_active", 64'(burst_active), 64'(bact | lk));
            chk("m_hmastlock", 64'(hmastlock), 64'(lk));
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            m_addr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
            m_trans[i] = 2'd0;
            m_write[i] = i[0];
            m_size[i]  = 3'(i % 3);
            m_burst[i] = 3'd0;
            m_wdata[i] = 32'hA0A0_0000 + 32'(i);
            m_lock[i]  = 1'b0;
        end
        reset = 1'b1; hready = 1'b1; hgrant_i = 5'b00100;
        step(2);

        // 1: first grant after reset release
        reset = 1'b0;
        step();
        chk("t1_hmaster", 64'(hmaster), 64'd2);
        chk("t1_haddr", 64'(haddr), 64'h1000_0200);
        chk("t1_vld", 64'(hmaster_vld), 64'd1);
        chk("t1_hwdata_none", 64'(hwdata), 64'd0);
        step();
        chk("t1_hwdata", 64'(hwdata), 64'hA0A0_0002);

        // 2: INCR4 from master 1
        hgrant_i = 5'b00010;
        m_addr[1] = 32'h2000_0000; m_trans[1] = 2'd2; m_burst[1] = 3'd3;
        step();
        chk("t2_owner", 64'(hmaster), 64'd1);
        step();
        chk("t2_act_b1", 64'(burst_active), 64'd1);
        m_trans[1] = 2'd3; m_addr[1] = 32'h2000_0004;
        step();
        m_addr[1] = 32'h2000_0008;
        step();
        chk("t2_act_b3", 64'(burst_active), 64'd1);
        m_addr[1] = 32'h2000_000C;
        step();
        chk("t2_act_b4", 64'(burst_active), 64'd0);

        // 3: wait states while the grant moves to master 4
        m_trans[1] = 2'd2; m_addr[1] = 32'h1000_0100;
        step();
        m_trans[1] = 2'd3; m_addr[1] = 32'h1000_0110;
        hready = 1'b0; hgrant_i = 5'b10000;
        step(3);
        chk("t3_hold_owner", 64'(hmaster), 64'd1);
        chk("t3_hold_addr", 64'(haddr), 64'h1000_0110);
        chk("t3_hold_act", 64'(burst_active), 64'd1);
        hready = 1'b1;
        step();
        chk("t3_switch", 64'(hmaster), 64'd4);
        step();
        chk("t3_act_clear", 64'(burst_active), 64'd0);
        m_trans[1] = 2'd0;

        // 2b: NONSEQ SINGLE terminates an INCR8 early
        hgrant_i = 5'b00010;
        m_trans[1] = 2'd2; m_burst[1] = 3'd5; m_addr[1] = 32'h3000_0000;
        step(2);
        chk("t2b_act", 64'(burst_active), 64'd1);
        m_burst[1] = 3'd0; m_addr[1] = 32'h3100_0000;
        step();
        chk("t2b_term", 64'(burst_active), 64'd0);
        m_trans[1] = 2'd0;

        // 4: invalid grants
        hgrant_i = 5'b00110;
        step();
        chk("t4_vld_multi", 64'(hmaster_vld), 64'd0);
        chk("t4_haddr_multi", 64'(haddr), 64'(DEF));
        hgrant_i = 5'b00000;
        step();
        chk("t4_vld_zero", 64'(hmaster_vld), 64'd0);
        chk("t4_htrans_zero", 64'(htrans), 64'd0);

        // 5: reset in the middle of a WRAP8 (with one BUSY)
        hgrant_i = 5'b00001;
        m_trans[0] = 2'd2; m_burst[0] = 3'd4; m_write[0] = 1'b1; m_addr[0] = 32'h4000_0000;
        step(2);
        m_trans[0] = 2'd1;
        step();
        chk("t5_busy_hold", 64'(burst_active), 64'd1);
        m_trans[0] = 2'd3; m_addr[0] = 32'h4000_0004;
        step();
        m_addr[0] = 32'h4000_0008;
        reset = 1'b1;
        step();
        chk("t5_rst_act", 64'(burst_active), 64'd0);
        chk("t5_rst_htrans", 64'(htrans), 64'd0);
        chk("t5_rst_hwdata", 64'(hwdata), 64'd0);
        reset = 1'b0; m_trans[0] = 2'd0; m_burst[0] = 3'd0;
        step(2);

`ifdef AHB_MUX_LOCK_EN
        // 6: locked SINGLE writes hold the grant
        m_lock[0] = 1'b1; m_trans[0] = 2'd2; m_write[0] = 1'b1;
        step();
        chk("t6_lock", 64'(hmastlock), 64'd1);
        chk("t6_act1", 64'(burst_active), 64'd1);
        m_addr[0] = 32'h4000_0010;
        step();
        chk("t6_act2", 64'(burst_active), 64'd1);
        m_lock[0] = 1'b0; m_trans[0] = 2'd0;
        step();
        chk("t6_unlock", 64'(hmastlock), 64'd0);
`endif

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
